// File: rtl/ahb_lite_slave_mem_pkg.sv
// Shared AHB-Lite encodings, slave FSM states and the byte-lane decode helper.
package AHBpkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    SizeByte = 3'b000,
    SizeHalf = 3'b001,
    SizeWord = 3'b010
  } hsize_t;

  typedef enum logic [2:0] {
    BurstSingle = 3'b000,
    BurstIncr   = 3'b001,
    BurstWrap4  = 3'b010,
    BurstIncr4  = 3'b011,
    BurstWrap8  = 3'b100,
    BurstIncr8  = 3'b101,
    BurstWrap16 = 3'b110,
    BurstIncr16 = 3'b111
  } hburst_t;

  typedef enum logic [1:0] {
    RespOkay  = 2'b00,
    RespError = 2'b01
  } hresp_t;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StData = 2'b01,
    StErr1 = 2'b10,
    StErr2 = 2'b11
  } state_t;

  // Only called for legal sizes; anything wider than a halfword maps to a full word.
  function automatic logic [3:0] byte_enables(input logic [2:0] size, input logic [1:0] lsb);
    case (size)
      3'(SizeByte): return 4'b0001 << lsb;
      3'(SizeHalf): return lsb[1] ? 4'b1100 : 4'b0011;
      default:      return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_bank.sv
// Word-organised storage: one byte-enabled write port, one asynchronous read port.
module ahb_sram_bank #(
  parameter int unsigned WORDS = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  // No reset: contents must survive a bus reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite memory slave: address decode, response FSM and wait-state counter around an SRAM bank.
module ahb_lite_slave_mem
  import AHBpkg::*;
#(
  parameter int unsigned MEM_WORDS   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  output logic        HREADY,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);

  localparam int unsigned AW       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [2:0]  WaitLoad = 3'(WAIT_STATES);

  state_t        state_q, state_d;
  logic [2:0]    wait_q, wait_d;
  logic [AW-1:0] addr_q;
  logic          write_q;
  logic [3:0]    be_q;

  logic          accept, illegal, complete, mem_we;
  logic [31:0]   mem_rdata;
  hresp_t        resp;

  // Bursts are just a sequence of master-addressed beats, so HBURST and SEQ/NONSEQ do not matter.
  logic unused_ctrl;
  assign unused_ctrl = ^{HBURST, HTRANS[0]};

  assign accept  = HREADY && HTRANS[1];
  assign illegal = ({2'b00, HADDR[31:2]} >= MEM_WORDS)
                || (HSIZE > 3'(SizeWord))
                || ((HSIZE == 3'(SizeHalf)) && HADDR[0])
                || ((HSIZE == 3'(SizeWord)) && (HADDR[1:0] != 2'b00));

  assign complete = (state_q == StData) && (wait_q == 3'd0);
  assign mem_we   = complete && write_q && !HRESET;

  always_comb begin
    HREADY = 1'b1;
    unique case (state_q)
      StData:  HREADY = (wait_q == 3'd0);
      StErr1:  HREADY = 1'b0;
      default: HREADY = 1'b1;
    endcase
  end

  assign resp   = ((state_q == StErr1) || (state_q == StErr2)) ? RespError : RespOkay;
  assign HRESP  = resp;
  assign HRDATA = (complete && !write_q) ? mem_rdata : 32'h0;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    if (state_q == StErr1) begin
      state_d = StErr2;
    end else if ((state_q == StData) && (wait_q != 3'd0)) begin
      wait_d = wait_q - 3'd1;
    end else if (accept) begin
      state_d = illegal ? StErr1 : StData;
      wait_d  = illegal ? 3'd0 : WaitLoad;
    end else begin
      state_d = StIdle;
      wait_d  = 3'd0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= StIdle;
      wait_q  <= 3'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      be_q    <= 4'b0000;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (accept && !illegal) begin
        addr_q  <= HADDR[AW+1:2];
        write_q <= HWRITE;
        be_q    <= byte_enables(HSIZE, HADDR[1:0]);
      end
    end
  end

  ahb_sram_bank #(
    .WORDS(MEM_WORDS),
    .AW   (AW)
  ) u_bank (
    .clk  (HCLK),
    .we   (mem_we),
    .be   (be_q),
    .waddr(addr_q),
    .wdata(HWDATA),
    .raddr(addr_q),
    .rdata(mem_rdata)
  );

endmodule
